// File: rtl/bank_collector.sv
// bank_collector: reads rotated batches from the bank BRAMs and streams them back de-rotated over valid/ready
module bank_collector #(
    parameter int CHANNEL_NUMBER    = 3,
    parameter int CHANNEL_BANDWIDTH = 128,
    parameter int BLOCK_DEPTH       = 480,
    parameter int READ_LATENCY      = 1,
    parameter int FIFO_DEPTH        = 4,
    localparam int AW = $clog2(BLOCK_DEPTH),
    localparam int LW = $clog2(BLOCK_DEPTH + 1)
) (
    input  logic                         I_clk,
    input  logic                         I_rst,
    input  logic                         I_start,
    input  logic [AW-1:0]                I_start_address,
    input  logic [LW-1:0]                I_length,
    output logic                         O_busy,
    output logic                         O_done,
    output logic                         O_bank_read_enable,
    output logic [AW-1:0]                O_bank_address [0:CHANNEL_NUMBER-1],
    input  logic [CHANNEL_BANDWIDTH-1:0] I_bank_data [0:CHANNEL_NUMBER-1],
    output logic [CHANNEL_BANDWIDTH-1:0] O_data [0:CHANNEL_NUMBER-1],
    output logic [AW-1:0]                O_address,
    output logic                         O_valid,
    input  logic                         I_ready
);
    localparam int N   = CHANNEL_NUMBER;
    localparam int BW  = CHANNEL_BANDWIDTH;
    localparam int LAT = READ_LATENCY;
    localparam int FD  = FIFO_DEPTH;
    localparam int RW  = N > 1 ? $clog2(N) : 1;
    localparam int OW  = $clog2(FD + 1);
    localparam int PW  = FD > 1 ? $clog2(FD) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, last_q, last_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [OW-1:0] out_q, out_d, cnt_q, cnt_d;
    logic [LAT-1:0] pv_q, pv_d;
    logic [RW-1:0] prot_q [0:LAT-1];
    logic [RW-1:0] prot_d [0:LAT-1];
    logic [AW-1:0] paddr_q [0:LAT-1];
    logic [AW-1:0] paddr_d [0:LAT-1];
    logic [BW-1:0] mem_q [0:FD-1][0:N-1];
    logic [BW-1:0] mem_d [0:FD-1][0:N-1];
    logic [AW-1:0] maddr_q [0:FD-1];
    logic [AW-1:0] maddr_d [0:FD-1];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          ren, accept, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(FD - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge I_clk) begin
        if (I_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (I_start) state_d = I_length == '0 ? DONE : READ;
            READ:    if (ren && rem_q == LW'(1)) state_d = DRAIN;
            DRAIN:   if (out_d == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Credit: out_q counts every read from issue until its beat leaves the FIFO
    always_comb begin
        ren                = state_q == READ && out_q < OW'(FD);
        O_bank_read_enable = ren;
        O_busy             = state_q == READ || state_q == DRAIN;
        O_done             = state_q == DONE;
        for (int k = 0; k < N; k++) O_bank_address[k] = ren ? addr_q : last_q;
    end

    assign O_valid   = cnt_q != '0;
    assign O_data    = mem_q[rd_q];
    assign O_address = maddr_q[rd_q];

    always_comb begin
        accept     = state_q == IDLE && I_start;
        push       = pv_q[LAT-1];
        pop        = O_valid && I_ready;
        addr_d     = accept ? I_start_address
                   : ren ? (addr_q == AW'(BLOCK_DEPTH - 1) ? '0 : addr_q + 1'b1) : addr_q;
        rem_d      = accept ? I_length : rem_q - LW'(ren);
        last_d     = ren ? addr_q : last_q;
        out_d      = out_q + OW'(ren) - OW'(pop);
        pv_d[0]    = ren;
        prot_d[0]  = RW'(addr_q % AW'(N));
        paddr_d[0] = addr_q;
        for (int i = 1; i < LAT; i++) begin
            pv_d[i]    = pv_q[i-1];
            prot_d[i]  = prot_q[i-1];
            paddr_d[i] = paddr_q[i-1];
        end
        mem_d   = mem_q;
        maddr_d = maddr_q;
        if (push) begin
            maddr_d[wr_q] = paddr_q[LAT-1];
            for (int k = 0; k < N; k++) mem_d[wr_q][k] = I_bank_data[(k + int'(prot_q[LAT-1])) % N];
        end
        wr_d  = push ? inc(wr_q) : wr_q;
        rd_d  = pop ? inc(rd_q) : rd_q;
        cnt_d = cnt_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            addr_q  <= '0;
            last_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            pv_q    <= '0;
            prot_q  <= '{default: '0};
            paddr_q <= '{default: '0};
            mem_q   <= '{default: '0};
            maddr_q <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            pv_q    <= pv_d;
            prot_q  <= prot_d;
            paddr_q <= paddr_d;
            mem_q   <= mem_d;
            maddr_q <= maddr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
